// File: rtl/mem_port_arbiter.sv
// Two-requester main-memory port arbiter: round-robin grant locked for the whole
// transaction, registered memory-side strobes/address/data, per-side completion counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read_i,
    input  logic              i_write_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [LINE_W-1:0] i_wdata_i,
    output logic [LINE_W-1:0] i_rdata_o,
    output logic              i_ready_o,

    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              d_ready_o,

    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,

    output logic [CNT_W-1:0]  i_grant_cnt_o,
    output logic [CNT_W-1:0]  d_grant_cnt_o
);

    // state   | meaning
    // IDLE    | waiting for a request; arbitrates on the next edge
    // BUSY    | transaction latched on the memory port, waiting for mem_ready_i
    // RELEASE | one dead cycle so the requester can drop its strobe
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    side_t             grant_q, grant_d;
    side_t             last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

    logic i_act;
    logic d_act;
    logic pick_d;
    logic busy;

    assign i_act  = i_read_i | i_write_i;
    assign d_act  = d_read_i | d_write_i;
    // On a tie the side that did not complete last wins.
    assign pick_d = d_act & (~i_act | (last_q == SIDE_I));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= SIDE_I;
            last_q      <= SIDE_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_cnt_q     <= '0;
            d_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_cnt_q     <= i_cnt_d;
            d_cnt_q     <= d_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_cnt_d     = i_cnt_q;
        d_cnt_d     = d_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_act | d_act) begin
                    state_d = ST_BUSY;
                    // A simultaneous read+write strobe is treated as a write.
                    if (pick_d) begin
                        grant_d     = SIDE_D;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        mem_write_d = d_write_i;
                        mem_read_d  = d_read_i & ~d_write_i;
                    end else begin
                        grant_d     = SIDE_I;
                        mem_addr_d  = i_addr_i;
                        mem_wdata_d = i_wdata_i;
                        mem_write_d = i_write_i;
                        mem_read_d  = i_read_i & ~i_write_i;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready_i) begin
                    state_d     = ST_RELEASE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    last_d      = grant_q;
                    if (grant_q == SIDE_D) begin
                        d_cnt_d = d_cnt_q + CNT_ONE;
                    end else begin
                        i_cnt_d = i_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    assign busy = (state_q == ST_BUSY);

    assign i_ready_o = busy & mem_ready_i & (grant_q == SIDE_I);
    assign d_ready_o = busy & mem_ready_i & (grant_q == SIDE_D);
    assign i_rdata_o = mem_rdata_i;
    assign d_rdata_o = mem_rdata_i;

    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign i_grant_cnt_o = i_cnt_q;
    assign d_grant_cnt_o = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives inputs just after the rising edge,
// checks outputs on the falling edge against hand-computed values.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst_n;
    logic              i_read_i, i_write_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [LINE_W-1:0] i_wdata_i, i_rdata_o;
    logic              i_ready_o;
    logic              d_read_i, d_write_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [LINE_W-1:0] d_wdata_i, d_rdata_o;
    logic              d_ready_o;
    logic              mem_read_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o, mem_rdata_i;
    logic              mem_ready_i;
    logic [CNT_W-1:0]  i_grant_cnt_o, d_grant_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read_i     (i_read_i),
        .i_write_i    (i_write_i),
        .i_addr_i     (i_addr_i),
        .i_wdata_i    (i_wdata_i),
        .i_rdata_o    (i_rdata_o),
        .i_ready_o    (i_ready_o),
        .d_read_i     (d_read_i),
        .d_write_i    (d_write_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_rdata_o    (d_rdata_o),
        .d_ready_o    (d_ready_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i),
        .i_grant_cnt_o(i_grant_cnt_o),
        .d_grant_cnt_o(d_grant_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read_i = 0; i_write_i = 0; i_addr_i = '0; i_wdata_i = '0;
        d_read_i = 0; d_write_i = 0; d_addr_i = '0; d_wdata_i = '0;
        mem_rdata_i = '0; mem_ready_i = 0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 0;
        clear_inputs();
        repeat (2) step();
        rst_n = 1;
    endtask

    // One-cycle memory completion; returns what each side saw during it.
    task automatic do_ready(input logic [127:0] rd, output logic ir, output logic dr,
                            output logic [127:0] ird, output logic [127:0] drd);
        step();
        mem_ready_i = 1;
        mem_rdata_i = rd;
        @(negedge clk);
        ir = i_ready_o; dr = d_ready_o; ird = i_rdata_o; drd = d_rdata_o;
        step();
        mem_ready_i = 0;
    endtask

    localparam logic [127:0] RD0 = 128'hDEADBEEF_01234567_89ABCDEF_00112233;
    localparam logic [127:0] WD2 = 128'hCAFEF00D_55AA55AA_0F0F0F0F_12345678;

    logic         ir, dr, bad, found;
    logic [127:0] ird, drd;
    int           gap;

    initial begin
        rst_n = 1;
        clear_inputs();

        // Reset then idle
        do_reset();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bad = bad | mem_read_o | mem_write_o | i_ready_o | d_ready_o;
            step();
        end
        check("idle_quiet", bad, 0);
        check("rst_i_cnt", i_grant_cnt_o, 0);
        check("rst_d_cnt", d_grant_cnt_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);

        // Single D read, ready three cycles after the request
        d_read_i = 1; d_addr_i = 28'h0000123;
        step();
        @(negedge clk);
        check("d_read_strobe", mem_read_o, 1);
        check("d_read_nowrite", mem_write_o, 0);
        check("d_read_addr", mem_addr_o, 28'h0000123);
        step();
        do_ready(RD0, ir, dr, ird, drd);
        d_read_i = 0;
        check("d_read_ready", dr, 1);
        check("d_read_i_quiet", ir, 0);
        check("d_read_rdata", drd, RD0);
        check("i_rdata_bcast", ird, RD0);
        @(negedge clk);
        check("d_read_strobe_off", mem_read_o, 0);
        check("d_read_ready_off", d_ready_o, 0);
        check("d_read_dcnt", d_grant_cnt_o, 1);
        check("d_read_icnt", i_grant_cnt_o, 0);
        step();

        // Simultaneous I read and D write: D first after reset
        do_reset();
        i_read_i = 1; i_addr_i = 28'h0ABCDEF;
        d_write_i = 1; d_addr_i = 28'h7654321; d_wdata_i = WD2;
        step();
        @(negedge clk);
        check("tie_d_write", mem_write_o, 1);
        check("tie_d_noread", mem_read_o, 0);
        check("tie_d_addr", mem_addr_o, 28'h7654321);
        check("tie_d_wdata", mem_wdata_o, WD2);
        do_ready(RD0, ir, dr, ird, drd);
        d_write_i = 0;
        check("tie_d_ready", dr, 1);
        check("tie_d_i_quiet", ir, 0);
        @(negedge clk);
        check("release_strobe", mem_write_o | mem_read_o, 0);
        check("release_addr_hold", mem_addr_o, 28'h7654321);
        step();
        @(negedge clk);
        check("idle_gap_strobe", mem_write_o | mem_read_o, 0);
        step();
        @(negedge clk);
        check("tie_i_read", mem_read_o, 1);
        check("tie_i_addr", mem_addr_o, 28'h0ABCDEF);
        do_ready(RD0, ir, dr, ird, drd);
        i_read_i = 0;
        check("tie_i_ready", ir, 1);
        check("tie_i_d_quiet", dr, 0);
        @(negedge clk);
        check("tie_icnt", i_grant_cnt_o, 1);
        check("tie_dcnt", d_grant_cnt_o, 1);

        // Both sides continuously requesting: strict alternation D,I,D,I,D,I
        do_reset();
        i_read_i = 1; i_addr_i = 28'h1111111;
        d_read_i = 1; d_addr_i = 28'h2222222;
        for (int t = 0; t < 6; t++) begin
            found = 0; gap = 0;
            for (int k = 0; k < 8 && !found; k++) begin
                @(negedge clk);
                if (mem_read_o || mem_write_o) found = 1;
                else begin
                    gap++;
                    step();
                end
            end
            check($sformatf("rr_found_%0d", t), found, 1);
            check($sformatf("rr_addr_%0d", t), mem_addr_o,
                  (t % 2 == 0) ? 28'h2222222 : 28'h1111111);
            if (t > 0) check($sformatf("rr_gap_%0d", t), gap >= 2, 1);
            do_ready(RD0, ir, dr, ird, drd);
            check($sformatf("rr_i_ready_%0d", t), ir, (t % 2 == 1));
            check($sformatf("rr_d_ready_%0d", t), dr, (t % 2 == 0));
        end
        i_read_i = 0; d_read_i = 0;
        @(negedge clk);
        check("rr_icnt", i_grant_cnt_o, 3);
        check("rr_dcnt", d_grant_cnt_o, 3);

        // D asserts read and write together
        do_reset();
        d_read_i = 1; d_write_i = 1; d_addr_i = 28'h0000ABC;
        step();
        @(negedge clk);
        check("rw_write", mem_write_o, 1);
        check("rw_read", mem_read_o, 0);
        do_ready(RD0, ir, dr, ird, drd);
        d_read_i = 0; d_write_i = 0;
        check("rw_ready", dr, 1);

        // I drops its request mid-BUSY (last = D, so I alone is granted)
        i_read_i = 1; i_addr_i = 28'h0FEDCBA;
        repeat (2) step();
        @(negedge clk);
        check("drop_strobe", mem_read_o, 1);
        check("drop_addr", mem_addr_o, 28'h0FEDCBA);
        step();
        i_read_i = 0;
        @(negedge clk);
        check("drop_hold", mem_read_o, 1);
        do_ready(RD0, ir, dr, ird, drd);
        check("drop_ready", ir, 1);
        check("drop_d_quiet", dr, 0);
        @(negedge clk);
        check("drop_icnt", i_grant_cnt_o, 1);

        // Spurious mem_ready_i outside BUSY
        step();
        step();
        mem_ready_i = 1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bad = bad | i_ready_o | d_ready_o | mem_read_o | mem_write_o;
            step();
        end
        mem_ready_i = 0;
        check("spurious_quiet", bad, 0);
        check("spurious_icnt", i_grant_cnt_o, 1);
        check("spurious_dcnt", d_grant_cnt_o, 1);

        // Reset while BUSY
        d_read_i = 1; d_addr_i = 28'h0333333;
        step();
        @(negedge clk);
        check("rstbusy_strobe", mem_read_o, 1);
        step();
        rst_n = 0;
        step();
        @(negedge clk);
        check("rstbusy_off", mem_read_o, 0);
        check("rstbusy_dready", d_ready_o, 0);
        check("rstbusy_icnt", i_grant_cnt_o, 0);
        check("rstbusy_dcnt", d_grant_cnt_o, 0);
        d_read_i = 0;
        rst_n = 1;
        step();
        mem_ready_i = 1;
        @(negedge clk);
        check("rstbusy_idle_noready", d_ready_o | i_ready_o, 0);
        step();
        mem_ready_i = 0;
        i_read_i = 1; i_addr_i = 28'h0444444;
        step();
        @(negedge clk);
        check("rstbusy_regrant", mem_read_o, 1);
        check("rstbusy_regrant_addr", mem_addr_o, 28'h0444444);
        i_read_i = 0;
        do_ready(RD0, ir, dr, ird, drd);
        check("rstbusy_final_ready", ir, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit main-memory port between the instruction-cache controller (I side) and the data-cache controller (D side).
- Each requester side mirrors the cache-controller memory interface: read/write strobes held until ready, 28-bit line address, 128-bit line data.
- Arbitration is round-robin with a locked grant per transaction and registered memory-side outputs.
- Per-requester transaction counters support performance analysis.

Parameters:
ADDR_W, 28, line-address width (word address >> 2)
LINE_W, 128, cache-line width in bits
CNT_W, 32, width of the grant counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
i_read_i  in  1  I-side line read request
i_write_i  in  1  I-side line write request
i_addr_i  in  ADDR_W  I-side line address
i_wdata_i  in  LINE_W  I-side write data
i_rdata_o  out  LINE_W  I-side read data
i_ready_o  out  1  I-side transaction-complete pulse
d_read_i  in  1  D-side line read request
d_write_i  in  1  D-side line write request
d_addr_i  in  ADDR_W  D-side line address
d_wdata_i  in  LINE_W  D-side write data
d_rdata_o  out  LINE_W  D-side read data
d_ready_o  out  1  D-side transaction-complete pulse
mem_read_o  out  1  memory read strobe
mem_write_o  out  1  memory write strobe
mem_addr_o  out  ADDR_W  memory line address
mem_wdata_o  out  LINE_W  memory write data
mem_rdata_i  in  LINE_W  memory read data
mem_ready_i  in  1  memory completion
i_grant_cnt_o  out  CNT_W  completed I-side transactions
d_grant_cnt_o  out  CNT_W  completed D-side transactions

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values (rst_n low at a clock edge):
  - state = IDLE.
  - mem_read_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - Both grant counters = 0.
  - Round-robin pointer last = I, so D wins the first tie.
  - i_ready_o and d_ready_o are 0 whenever state is not BUSY.
- Reset mid-transaction: the transaction is abandoned with no ready pulse. The memory strobes are 0 from the cycle after the reset edge.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Requester X is "active" when X_read_i or X_write_i is high.
  - Neither active: stay in IDLE.
  - One active: grant it.
  - Both active: grant the side that is not `last`.
  - On grant (edge N), latch the granted side's address, wdata, read and write into the mem_* output registers, set grant = X, and go to BUSY.
  - If a side asserts both read and write, the latched strobes are write=1, read=0 (write takes precedence).
- Latency: a request seen at edge N gives mem strobes high from after edge N until the edge following mem_ready_i.
- BUSY:
  - mem_* outputs hold the latched values; requester-input changes are ignored, including a requester dropping its request.
  - X_ready_o = mem_ready_i AND (grant == X), combinational and same cycle.
  - X_rdata_o = mem_rdata_i for both sides always (broadcast); requesters sample it only with ready.
  - On an edge with mem_ready_i = 1: clear mem_read_o and mem_write_o, set last = grant, increment the granted side's counter, and go to RELEASE.
  - Otherwise stay in BUSY, with no timeout.
- RELEASE:
  - Lasts exactly one cycle, with strobes 0 and requests ignored, so the requester's strobe deassertion is observed; then go to IDLE.
  - Back-to-back transactions are therefore at least 2 cycles apart at the memory.
- mem_ready_i in IDLE or RELEASE is ignored: no ready pulse, no counter change.
- Counters wrap modulo 2^CNT_W. Only the granted side's counter changes, by exactly 1 per completed transaction.
- mem_addr_o and mem_wdata_o keep their last latched values outside BUSY; only the strobes return to 0.
- Fairness: with both sides continuously requesting, grants strictly alternate.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, with no requests -> all mem strobes 0, counters 0, no ready pulses for 20 cycles.
- Single D read: d_read_i=1, d_addr_i=0x0000123, memory returns 0xDEADBEEF_... with ready 3 cycles later -> mem_read_o=1 and mem_addr_o=0x0000123 from the cycle after the request; d_ready_o pulses 1 cycle with d_rdata_o matching; i_ready_o stays 0; d_grant_cnt_o=1.
- Simultaneous I read and D write after reset -> D is granted first (mem_write_o=1, D addr and wdata); after D's ready and RELEASE, I is granted; counters are 1/1.
- Both sides requesting continuously for 6 transactions -> grant order D,I,D,I,D,I; at least 2 cycles between strobe sessions; each ready pulse is routed only to the granted side.
- D asserts d_read_i and d_write_i together -> mem_write_o=1, mem_read_o=0.
- Requester drops its request mid-BUSY -> latched transaction completes and the ready pulse is still issued.
- Spurious mem_ready_i in IDLE -> ignored.
- rst_n=0 while BUSY -> strobes 0 the next cycle, state IDLE, no ready pulse, counters 0.
